// File: rtl/din_syn_receiver.sv
// ---------------------------------------------------------------------------
// din_syn_receiver
//
// Receive end of the DIN/CLK/SYNC serial shift-register link. The three link
// lines are oversampled on clk_in through SYNC_STAGES-deep synchronisers. DIN
// is shifted in MSB-first on every rising edge of the serial clock while the
// active-low SYNC is asserted. A completed frame of exactly WIDTH bits is
// presented on data_reg; any other length is reported as a framing error.
//
// Ports
//   clk_in        in   1      system clock (>= 4x serial clock rate)
//   rst           in   1      synchronous, active-high reset
//   ser_clk       in   1      link serial clock (async)
//   ser_din       in   1      link serial data (async)
//   ser_syn       in   1      link frame sync, active low (async)
//   data_reg      out  WIDTH  last valid frame, [WIDTH-1] = first bit received
//   bit_cnt       out  CNT_W  bits counted in current/last frame, saturating
//   busy          out  1      high while a frame is being shifted in
//   frame_valid   out  1      1-cycle pulse, data_reg updated with a good frame
//   frame_err     out  1      1-cycle pulse, frame ended with bit_cnt != WIDTH
//   expected_reg  in   WIDTH  reference word for compare    (SHR_RX_CMP_EN)
//   cmp_mismatch  out  1      sticky compare-failure flag   (SHR_RX_CMP_EN)
//
// Build option
//   SHR_RX_CMP_EN  when defined, adds expected_reg/cmp_mismatch and the
//                  comparator that checks every good frame against
//                  expected_reg. Undefined: ports and comparator are absent.
//
// State | meaning
// ------+------------------------------------------------------------------
// ARM   | after reset, wait until synced SYNC is reliably high (idle link)
// IDLE  | between frames, wait for SYNC to go low
// SHIFT | frame in progress, shift DIN on each serial clock rising edge
// DONE  | frame closed, publish data (good length) or flag error
// ---------------------------------------------------------------------------
module din_syn_receiver #(
    parameter int WIDTH       = 644,
    parameter int CNT_W       = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             ser_clk,
    input  logic             ser_din,
    input  logic             ser_syn,
    output logic [WIDTH-1:0] data_reg,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             busy,
    output logic             frame_valid,
    output logic             frame_err
`ifdef SHR_RX_CMP_EN
    ,
    input  logic [WIDTH-1:0] expected_reg,
    output logic             cmp_mismatch
`endif
);

    typedef enum logic [1:0] {
        ST_ARM   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
    localparam int               ARM_W   = $clog2(SYNC_STAGES + 1);
    localparam logic [ARM_W-1:0] ARM_LD  = ARM_W'(SYNC_STAGES);

    // Input synchronisers, stage 0 samples the pin.
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] din_sync_q;
    logic [SYNC_STAGES-1:0] syn_sync_q;
    logic                   clk_prev_q;

    logic clk_s;
    logic din_s;
    logic syn_s;
    logic clk_rise;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            clk_sync_q <= '0;
            din_sync_q <= '0;
            syn_sync_q <= '1;
            clk_prev_q <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ser_clk};
            din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], ser_din};
            syn_sync_q <= {syn_sync_q[SYNC_STAGES-2:0], ser_syn};
            clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign clk_s    = clk_sync_q[SYNC_STAGES-1];
    assign din_s    = din_sync_q[SYNC_STAGES-1];
    assign syn_s    = syn_sync_q[SYNC_STAGES-1];
    assign clk_rise = clk_s & ~clk_prev_q;

    // FSM and datapath registers.
    state_t           state_q;
    logic [ARM_W-1:0] arm_cnt_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [CNT_W-1:0] bit_cnt_d;
    logic [WIDTH-1:0] data_q;
    logic             busy_q;
    logic             valid_q;
    logic             err_q;
`ifdef SHR_RX_CMP_EN
    logic             cmp_q;
`endif

    always_comb begin
        shift_d   = {shift_q[WIDTH-2:0], din_s};
        bit_cnt_d = (&bit_cnt_q) ? bit_cnt_q : bit_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q   <= ST_ARM;
            arm_cnt_q <= ARM_LD;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
`ifdef SHR_RX_CMP_EN
            cmp_q     <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                // The synchroniser chain still holds its reset (idle) levels
                // for SYNC_STAGES cycles after reset, so SYNC must be seen high
                // for SYNC_STAGES+1 consecutive cycles before trusting it.
                // Otherwise a link that was mid-frame during reset would open
                // a partial frame.
                ST_ARM: begin
                    if (!syn_s) begin
                        arm_cnt_q <= ARM_LD;
                    end else if (arm_cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        arm_cnt_q <= arm_cnt_q - ARM_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (!syn_s) begin
                        state_q   <= ST_SHIFT;
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // An edge coinciding with SYNC release still belongs to the frame.
                    if (clk_rise) begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_d;
                    end
                    if (syn_s) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    if (bit_cnt_q == WIDTH_C) begin
                        data_q  <= shift_q;
                        valid_q <= 1'b1;
`ifdef SHR_RX_CMP_EN
                        cmp_q   <= cmp_q | (shift_q != expected_reg);
`endif
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_ARM;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_reg    = data_q;
    assign bit_cnt     = bit_cnt_q;
    assign busy        = busy_q;
    assign frame_valid = valid_q;
    assign frame_err   = err_q;
`ifdef SHR_RX_CMP_EN
    assign cmp_mismatch = cmp_q;
`endif

endmodule

// File: tb/tb_din_syn_receiver.sv
module tb_din_syn_receiver;

    localparam int WIDTH       = 8;
    localparam int CNT_W       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int LATENCY     = SYNC_STAGES + 2;

    logic             clk_in = 1'b0;
    logic             rst;
    logic             ser_clk;
    logic             ser_din;
    logic             ser_syn;
    logic [WIDTH-1:0] data_reg;
    logic [CNT_W-1:0] bit_cnt;
    logic             busy;
    logic             frame_valid;
    logic             frame_err;
`ifdef SHR_RX_CMP_EN
    logic [WIDTH-1:0] expected_reg;
    logic             cmp_mismatch;
`endif

    din_syn_receiver #(
        .WIDTH       (WIDTH),
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .ser_clk      (ser_clk),
        .ser_din      (ser_din),
        .ser_syn      (ser_syn),
        .data_reg     (data_reg),
        .bit_cnt      (bit_cnt),
        .busy         (busy),
        .frame_valid  (frame_valid),
        .frame_err    (frame_err)
`ifdef SHR_RX_CMP_EN
        ,
        .expected_reg (expected_reg),
        .cmp_mismatch (cmp_mismatch)
`endif
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic             ok;
        logic [WIDTH-1:0] data;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every frame pulse is matched against the oldest expectation.
    always @(negedge clk_in) begin
        if (!rst && (frame_valid || frame_err)) begin
            if (sb.size() == 0) begin
                check("pulse_without_frame", {30'd0, frame_valid, frame_err}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_kind", {30'd0, frame_valid, frame_err},
                      e.ok ? 32'd2 : 32'd1);
                check("data_reg", {24'd0, data_reg}, {24'd0, e.data});
                check("bit_cnt", {28'd0, bit_cnt}, {28'd0, e.cnt});
            end
        end
    end

    // Drives one serial bit: 4 clk_in cycles low, then the rising edge with din held.
    task automatic send_bit(input logic b, input bit raise_syn);
        ser_din = b;
        ser_clk = 1'b0;
        repeat (4) @(negedge clk_in);
        if (raise_syn) ser_syn = 1'b1;
        ser_clk = 1'b1;
        if (!raise_syn) repeat (4) @(negedge clk_in);
    endtask

    task automatic run_frame(input string tag, input logic [15:0] bits, input int n,
                             input bit syn_on_last, input bit exp_ok,
                             input logic [WIDTH-1:0] exp_data);
        int lat;
        sb.push_back('{ok: exp_ok, data: exp_data, cnt: CNT_W'(n)});
        @(negedge clk_in);
        ser_clk = 1'b0;
        ser_syn = 1'b0;
        repeat (4) @(negedge clk_in);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(bits[i], (i == 0) && syn_on_last);
            if (i == n - 1 && n > 1) check({tag, "_busy_mid"}, {31'd0, busy}, 32'd1);
        end
        if (!syn_on_last) begin
            ser_clk = 1'b0;
            repeat (4) @(negedge clk_in);
            ser_syn = 1'b1;
        end
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk_in);
            if (lat == 0 && (frame_valid || frame_err)) lat = k;
        end
        check({tag, "_latency"}, lat, LATENCY);
        check({tag, "_drain"}, sb.size(), 0);
        check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst = 1'b1;
        repeat (3) @(negedge clk_in);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        ser_clk = 1'b0;
        ser_din = 1'b0;
        ser_syn = 1'b1;
`ifdef SHR_RX_CMP_EN
        expected_reg = 8'hA5;
`endif
        repeat (4) @(negedge clk_in);
        check("rst_data_reg", {24'd0, data_reg}, 32'd0);
        check("rst_bit_cnt", {28'd0, bit_cnt}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, frame_valid}, 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        repeat (8) @(negedge clk_in);

        // 1: good frame A5
        run_frame("t1_a5", 16'h00A5, 8, 1'b0, 1'b1, 8'hA5);
        // 2: short frame, data held
        run_frame("t2_short", 16'h0052, 7, 1'b0, 1'b0, 8'hA5);
        // 3: long frame 1,1,1,1,1,1,1,1,0
        run_frame("t3_long", 16'h01FE, 9, 1'b0, 1'b0, 8'hA5);
        check("t3_cnt_kept", {28'd0, bit_cnt}, 32'd9);
        // zero-bit frame
        run_frame("t_zero", 16'h0000, 0, 1'b0, 1'b0, 8'hA5);

        // 4: reset mid-frame with SYNC held low
        @(negedge clk_in);
        ser_syn = 1'b0;
        repeat (4) @(negedge clk_in);
        for (int i = 3; i >= 0; i--) send_bit(i[0], 1'b0);
        do_reset();
        repeat (10) @(negedge clk_in);
        check("t4_abort_busy", {31'd0, busy}, 32'd0);
        check("t4_abort_data", {24'd0, data_reg}, 32'd0);
        check("t4_abort_cnt", {28'd0, bit_cnt}, 32'd0);
        ser_syn = 1'b1;
        repeat (12) @(negedge clk_in);
        check("t4_no_pulse", sb.size(), 0);
        run_frame("t4_3c", 16'h003C, 8, 1'b0, 1'b1, 8'h3C);

        // 5: SYNC rises with the 8th serial clock edge
        run_frame("t5_edge", 16'h00C3, 8, 1'b1, 1'b1, 8'hC3);

`ifdef SHR_RX_CMP_EN
        // 6: sticky compare against expected_reg
        do_reset();
        repeat (8) @(negedge clk_in);
        check("t6_rst_cmp", {31'd0, cmp_mismatch}, 32'd0);
        run_frame("t6_a5", 16'h00A5, 8, 1'b0, 1'b1, 8'hA5);
        check("t6_cmp_a5", {31'd0, cmp_mismatch}, 32'd0);
        run_frame("t6_a4", 16'h00A4, 8, 1'b0, 1'b1, 8'hA4);
        check("t6_cmp_a4", {31'd0, cmp_mismatch}, 32'd1);
        run_frame("t6_a5b", 16'h00A5, 8, 1'b0, 1'b1, 8'hA5);
        check("t6_cmp_sticky", {31'd0, cmp_mismatch}, 32'd1);
        do_reset();
        @(negedge clk_in);
        check("t6_cmp_cleared", {31'd0, cmp_mismatch}, 32'd0);
        repeat (8) @(negedge clk_in);
`endif

        repeat (4) @(negedge clk_in);
        check("final_pending", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
